// File: rtl/user_step_input_if.sv
// Front-panel bundle between the raw panel controls and the step/mode outputs
// that feed the user clock generator.
interface user_step_input_if;
  logic       button_raw;
  logic [1:0] switches_raw;
  logic       step;
  logic [1:0] mode;

  modport master (output button_raw, output switches_raw, input step, input mode);
  modport slave  (input button_raw, input switches_raw, output step, output mode);
endinterface

// File: rtl/user_step_input.sv
// Synchronizes and debounces the single-step button and mode switches, turning each
// press into fixed-width step pulses with auto-repeat; mode only updates while idle.
module user_step_input #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned PULSE_CYCLES    = 2500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input logic             source_clock,
  input logic             reset,
  user_step_input_if.slave bus
);

  localparam int unsigned CNT_W = 32;
  localparam int unsigned NCH   = 3;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PULSE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  logic [NCH-1:0]   raw;
  logic [NCH-1:0]   sync1;
  logic [NCH-1:0]   sync2;
  logic [NCH-1:0]   stable;
  logic [CNT_W-1:0] db_cnt [NCH];

  logic             btn;
  logic             btn_prev;
  logic [1:0]       sw;

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic             step_q;
  logic             step_next;
  logic             repeating;
  logic             repeating_next;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] timer_next;
  logic [CNT_W-1:0] timer_inc;
  logic [CNT_W-1:0] interval;
  logic [1:0]       mode_q;

  // Channel 0 is the button, channels 2:1 are the mode switches.
  assign raw = {bus.switches_raw, bus.button_raw};
  assign btn = stable[0];
  assign sw  = stable[2:1];

  // Two-flop synchronizer followed by a per-channel stability counter.
  always_ff @(negedge source_clock) begin
    if (reset) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int unsigned i = 0; i < NCH; i++) begin
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] + CNT_W'(1) == CNT_W'(DEBOUNCE_CYCLES)) begin
          stable[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign timer_inc = timer + CNT_W'(1);
  assign interval  = repeating ? CNT_W'(REPEAT_PERIOD) : CNT_W'(REPEAT_DELAY);

  // Step sequencing: pulse on press, then auto-repeat while held.
  always_comb begin
    state_next     = state;
    step_next      = step_q;
    repeating_next = repeating;
    timer_next     = timer_inc;
    case (state)
      IDLE: begin
        step_next      = 1'b0;
        repeating_next = 1'b0;
        timer_next     = '0;
        if (btn && !btn_prev) begin
          state_next = PULSE;
          step_next  = 1'b1;
        end
      end
      PULSE: begin
        if (timer_inc == CNT_W'(PULSE_CYCLES)) begin
          step_next  = 1'b0;
          state_next = WAIT;
        end
      end
      WAIT: begin
        // Release wins over a coincident repeat so a held-then-released button never extra-steps.
        if (!btn) begin
          state_next     = IDLE;
          repeating_next = 1'b0;
          timer_next     = '0;
        end else if (timer_inc == interval) begin
          state_next     = PULSE;
          step_next      = 1'b1;
          repeating_next = 1'b1;
          timer_next     = '0;
        end
      end
      default: begin
        state_next     = IDLE;
        step_next      = 1'b0;
        repeating_next = 1'b0;
        timer_next     = '0;
      end
    endcase
  end

  always_ff @(negedge source_clock) begin
    if (reset) begin
      state     <= IDLE;
      step_q    <= 1'b0;
      repeating <= 1'b0;
      timer     <= '0;
      btn_prev  <= 1'b0;
      mode_q    <= 2'b00;
    end else begin
      state     <= state_next;
      step_q    <= step_next;
      repeating <= repeating_next;
      timer     <= timer_next;
      btn_prev  <= btn;
      // Mode follows the switches only between press sequences.
      if (state == IDLE) begin
        mode_q <= sw;
      end
    end
  end

  assign bus.step = step_q;
  assign bus.mode = mode_q;

endmodule

// File: tb/tb_user_step_input.sv
// Directed bench for user_step_input with short debounce/pulse/repeat timing.
// "Edge n" is the n-th falling clock edge after an input is set just past edge 0.
module tb_user_step_input;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  user_step_input_if bus ();

  user_step_input #(
    .DEBOUNCE_CYCLES(4),
    .PULSE_CYCLES   (3),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (8)
  ) dut (
    .source_clock(clk),
    .reset       (reset),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Return just after a falling edge so outputs are settled and new inputs land before the next edge.
  task automatic next_edge();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int idx, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d]: observed %0b expected %0b", tag, idx, obs, exp);
    end
  endtask

  initial begin
    int rises[6];
    logic exp_step;

    checks = 0;
    errors = 0;
    rises  = '{7, 27, 35, 43, 51, 59};

    // Reset held for two edges while inputs toggle.
    reset            = 1'b1;
    bus.button_raw   = 1'b0;
    bus.switches_raw = 2'b00;
    for (int k = 0; k < 2; k++) begin
      next_edge();
      check("rst_step", k, {1'b0, bus.step}, 2'b00);
      check("rst_mode", k, bus.mode, 2'b00);
      bus.button_raw   = ~bus.button_raw;
      bus.switches_raw = bus.switches_raw + 2'd1;
    end
    reset            = 1'b0;
    bus.button_raw   = 1'b0;
    bus.switches_raw = 2'b00;
    for (int k = 1; k <= 10; k++) begin
      next_edge();
      check("post_rst_step", k, {1'b0, bus.step}, 2'b00);
      check("post_rst_mode", k, bus.mode, 2'b00);
    end

    // Clean press, released after edge 12.
    bus.button_raw = 1'b1;
    for (int e = 1; e <= 30; e++) begin
      next_edge();
      exp_step = (e >= 7 && e <= 9);
      check("clean", e, {1'b0, bus.step}, {1'b0, exp_step});
      if (e == 12) bus.button_raw = 1'b0;
    end

    // Bounces of 3 high cycles never reach the debounce threshold.
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 4; c++) begin
        bus.button_raw = (c < 3);
        next_edge();
        check("bounce", r * 4 + c, {1'b0, bus.step}, 2'b00);
      end
    end
    bus.button_raw = 1'b0;
    for (int c = 0; c < 4; c++) begin
      next_edge();
      check("bounce_tail", c, {1'b0, bus.step}, 2'b00);
    end

    // A final 5-cycle high is accepted as one press.
    bus.button_raw = 1'b1;
    for (int f = 1; f <= 25; f++) begin
      next_edge();
      exp_step = (f >= 7 && f <= 9);
      check("final_press", f, {1'b0, bus.step}, {1'b0, exp_step});
      if (f == 5) bus.button_raw = 1'b0;
    end

    // Held for 60 cycles: initial pulse, one long delay, then the repeat period.
    bus.button_raw = 1'b1;
    for (int e = 1; e <= 75; e++) begin
      next_edge();
      exp_step = 1'b0;
      foreach (rises[i]) begin
        if (e >= rises[i] && e <= rises[i] + 2) exp_step = 1'b1;
      end
      check("repeat", e, {1'b0, bus.step}, {1'b0, exp_step});
      if (e == 60) bus.button_raw = 1'b0;
    end

    // Switch change during a pulse waits for the state machine to return to IDLE.
    bus.button_raw = 1'b1;
    for (int g = 1; g <= 20; g++) begin
      next_edge();
      exp_step = (g >= 7 && g <= 9);
      check("gate_step", g, {1'b0, bus.step}, {1'b0, exp_step});
      check("gate_mode", g, bus.mode, (g >= 16) ? 2'b11 : 2'b00);
      if (g == 8) begin
        bus.switches_raw = 2'b11;
        bus.button_raw   = 1'b0;
      end
    end

    // Switch change while idle reaches mode after the debounce latency.
    bus.switches_raw = 2'b10;
    for (int h = 1; h <= 10; h++) begin
      next_edge();
      check("idle_mode", h, bus.mode, (h >= 7) ? 2'b10 : 2'b11);
    end

    // Reset on the second high cycle of step, button still held afterwards.
    bus.button_raw = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      next_edge();
      exp_step = (k >= 7);
      check("pre_rst_step", k, {1'b0, bus.step}, {1'b0, exp_step});
    end
    reset = 1'b1;
    next_edge();
    check("mid_rst_step", 9, {1'b0, bus.step}, 2'b00);
    check("mid_rst_mode", 9, bus.mode, 2'b00);
    reset = 1'b0;
    for (int k = 10; k <= 22; k++) begin
      next_edge();
      exp_step = (k >= 16 && k <= 18);
      check("after_rst", k, {1'b0, bus.step}, {1'b0, exp_step});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
